// File: rtl/prt_dp_pkg.sv
// Shared definitions for the local-bus arbiter: FSM state type, status bit map and defaults.
package prt_dp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_st_e;

  localparam int DAT_W    = 32;

  localparam int STA_OVF0 = 0;
  localparam int STA_OVF1 = 1;
  localparam int STA_TO   = 2;
  localparam int STA_BUSY = 3;

  localparam int               TO_CYC_DEF = 1024;
  localparam logic [DAT_W-1:0] TO_DAT_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/prt_dp_lb_arb_req.sv
// One-deep request holding register for a strobe-only local-bus master.
module prt_dp_lb_arb_req
  import prt_dp_pkg::*;
#(
  parameter int P_ADR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_i,
  input  logic                   rd_i,
  input  logic [P_ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_W-1:0]       din_i,
  input  logic                   issue_i,
  output logic                   vld_o,
  output logic                   is_rd_o,
  output logic [P_ADR_WIDTH-1:0] adr_o,
  output logic [DAT_W-1:0]       din_o,
  output logic                   ovf_o
);

  logic                   vld_q, vld_d;
  logic                   is_rd_q, is_rd_d;
  logic [P_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [DAT_W-1:0]       din_q, din_d;
  logic                   strobe;
  logic                   room;

  assign strobe = wr_i | rd_i;
  // The slot frees up in the same cycle it is issued, so a strobe then is still accepted.
  assign room   = ~vld_q | issue_i;
  assign ovf_o  = (strobe & ~room) | (wr_i & rd_i);

  always_comb begin
    vld_d   = vld_q;
    is_rd_d = is_rd_q;
    adr_d   = adr_q;
    din_d   = din_q;
    if (issue_i) begin
      vld_d = 1'b0;
    end
    if (strobe && room) begin
      vld_d   = 1'b1;
      is_rd_d = ~wr_i;
      adr_d   = adr_i;
      din_d   = din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q   <= 1'b0;
      is_rd_q <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      is_rd_q <= is_rd_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
    end
  end

  assign vld_o   = vld_q;
  assign is_rd_o = is_rd_q;
  assign adr_o   = adr_q;
  assign din_o   = din_q;

endmodule

// File: rtl/prt_dp_lb_arb.sv
// Two-master round-robin local-bus arbiter with one outstanding read and read timeout.
//   state      | meaning
//   ST_IDLE    | no slave access in flight; grant a held request if any
//   ST_ISSUE   | slave wr/rd strobe is on the bus this cycle
//   ST_WAIT_RD | waiting for slave read data or timeout expiry
module prt_dp_lb_arb
  import prt_dp_pkg::*;
#(
  parameter int               P_ADR_WIDTH = 32,
  parameter int               P_TO_CYC    = TO_CYC_DEF,
  parameter logic [DAT_W-1:0] P_TO_DAT    = TO_DAT_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [P_ADR_WIDTH-1:0] m0_adr_i,
  input  logic                   m0_wr_i,
  input  logic                   m0_rd_i,
  input  logic [DAT_W-1:0]       m0_din_i,
  output logic [DAT_W-1:0]       m0_dout_o,
  output logic                   m0_vld_o,
  input  logic [P_ADR_WIDTH-1:0] m1_adr_i,
  input  logic                   m1_wr_i,
  input  logic                   m1_rd_i,
  input  logic [DAT_W-1:0]       m1_din_i,
  output logic [DAT_W-1:0]       m1_dout_o,
  output logic                   m1_vld_o,
  output logic [P_ADR_WIDTH-1:0] s_adr_o,
  output logic                   s_wr_o,
  output logic                   s_rd_o,
  output logic [DAT_W-1:0]       s_din_o,
  input  logic [DAT_W-1:0]       s_dout_i,
  input  logic                   s_vld_i,
  input  logic                   clr_i,
  output logic [3:0]             sta_o
);

  localparam int TO_W = $clog2(P_TO_CYC + 1);

  arb_st_e                st_q, st_d;
  logic                   rr_q, rr_d;
  logic                   own_q, own_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [P_ADR_WIDTH-1:0] s_adr_q, s_adr_d;
  logic [DAT_W-1:0]       s_din_q, s_din_d;
  logic                   s_wr_q, s_wr_d, s_rd_q, s_rd_d;
  logic [DAT_W-1:0]       m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
  logic                   m0_vld_q, m0_vld_d, m1_vld_q, m1_vld_d;
  logic [2:0]             sta_q, sta_d, sta_set;

  logic                   h0_vld, h0_rd, h0_ovf, h1_vld, h1_rd, h1_ovf;
  logic [P_ADR_WIDTH-1:0] h0_adr, h1_adr;
  logic [DAT_W-1:0]       h0_din, h1_din;
  logic                   iss0, iss1, gnt_m1;
  logic                   ret, ret_to;
  logic [DAT_W-1:0]       ret_dat;

  prt_dp_lb_arb_req #(.P_ADR_WIDTH(P_ADR_WIDTH)) u_req0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_i(m0_wr_i), .rd_i(m0_rd_i), .adr_i(m0_adr_i),
    .din_i(m0_din_i), .issue_i(iss0), .vld_o(h0_vld), .is_rd_o(h0_rd), .adr_o(h0_adr),
    .din_o(h0_din), .ovf_o(h0_ovf)
  );

  prt_dp_lb_arb_req #(.P_ADR_WIDTH(P_ADR_WIDTH)) u_req1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_i(m1_wr_i), .rd_i(m1_rd_i), .adr_i(m1_adr_i),
    .din_i(m1_din_i), .issue_i(iss1), .vld_o(h1_vld), .is_rd_o(h1_rd), .adr_o(h1_adr),
    .din_o(h1_din), .ovf_o(h1_ovf)
  );

  always_comb begin
    st_d     = st_q;
    rr_d     = rr_q;
    own_d    = own_q;
    to_cnt_d = to_cnt_q;
    s_adr_d  = s_adr_q;
    s_din_d  = s_din_q;
    s_wr_d   = 1'b0;
    s_rd_d   = 1'b0;
    iss0     = 1'b0;
    iss1     = 1'b0;
    gnt_m1   = 1'b0;
    ret      = 1'b0;
    ret_to   = 1'b0;
    ret_dat  = s_dout_i;
    case (st_q)
      ST_IDLE: begin
        if (h0_vld || h1_vld) begin
          gnt_m1  = h1_vld & (~h0_vld | rr_q);
          iss0    = ~gnt_m1;
          iss1    = gnt_m1;
          rr_d    = ~gnt_m1;
          own_d   = gnt_m1;
          s_adr_d = gnt_m1 ? h1_adr : h0_adr;
          s_din_d = gnt_m1 ? h1_din : h0_din;
          s_rd_d  = gnt_m1 ? h1_rd : h0_rd;
          s_wr_d  = ~s_rd_d;
          st_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_rd_q) begin
          to_cnt_d = TO_W'(P_TO_CYC);
          st_d     = ST_WAIT_RD;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        to_cnt_d = to_cnt_q - 1'b1;
        // Terminal count is taken as the counter steps to zero; real data beats a coincident expiry.
        if (s_vld_i) begin
          ret = 1'b1;
        end else if (to_cnt_q == TO_W'(1)) begin
          ret     = 1'b1;
          ret_to  = 1'b1;
          ret_dat = P_TO_DAT;
        end
        if (ret) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m0_vld_d  = ret & ~own_q;
    m1_vld_d  = ret & own_q;
    m0_dout_d = m0_vld_d ? ret_dat : m0_dout_q;
    m1_dout_d = m1_vld_d ? ret_dat : m1_dout_q;
    sta_set           = '0;
    sta_set[STA_OVF0] = h0_ovf;
    sta_set[STA_OVF1] = h1_ovf;
    sta_set[STA_TO]   = ret_to;
    sta_d = (sta_q & {3{~clr_i}}) | sta_set;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q      <= ST_IDLE;
      rr_q      <= 1'b0;
      own_q     <= 1'b0;
      to_cnt_q  <= '0;
      s_adr_q   <= '0;
      s_din_q   <= '0;
      s_wr_q    <= 1'b0;
      s_rd_q    <= 1'b0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
      m0_vld_q  <= 1'b0;
      m1_vld_q  <= 1'b0;
      sta_q     <= '0;
    end else begin
      st_q      <= st_d;
      rr_q      <= rr_d;
      own_q     <= own_d;
      to_cnt_q  <= to_cnt_d;
      s_adr_q   <= s_adr_d;
      s_din_q   <= s_din_d;
      s_wr_q    <= s_wr_d;
      s_rd_q    <= s_rd_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
      m0_vld_q  <= m0_vld_d;
      m1_vld_q  <= m1_vld_d;
      sta_q     <= sta_d;
    end
  end

  assign s_adr_o   = s_adr_q;
  assign s_din_o   = s_din_q;
  assign s_wr_o    = s_wr_q;
  assign s_rd_o    = s_rd_q;
  assign m0_dout_o = m0_dout_q;
  assign m1_dout_o = m1_dout_q;
  assign m0_vld_o  = m0_vld_q;
  assign m1_vld_o  = m1_vld_q;
  assign sta_o     = {(st_q != ST_IDLE) | h0_vld | h1_vld, sta_q};

endmodule
